skinny_subcells_serial: RTL and testbench

- Nibble-serial SubCells stage for the Skinny-64 round datapath.
- Accepts a full 64-bit state over a valid/ready handshake.
- Streams the 16 nibbles one per cycle through a single registered 4-bit Skinny S-box, reassembles the substituted state, and presents it downstream over valid/ready.
- Sits between the round-state register/AddConstants and ShiftRows; the single-S-box datapath is the low-area serial variant used for masking case studies.

---
 rtl/skinny_pkg.sv | 31 +++
 rtl/skinny_sbox4_reg.sv | 30 +++
 rtl/skinny_subcells_serial.sv | 114 +++++++++++
 tb/tb_skinny_subcells_serial.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/skinny_pkg.sv
// Shared types and constants for the Skinny-64 serial SubCells stage.
// Holds the 4-bit S-box tables, state/nibble typedefs and the FSM encoding.
// No logic lives here; the inverse table is used only when SKINNY_SUBCELLS_INV_EN is defined.
package skinny_pkg;

  typedef logic [63:0] state_t;
  typedef logic [3:0]  nib_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fsm_e;

  localparam int NUM_NIB_DEF = 16;
  localparam int LATENCY     = 18;

  // Forward Skinny-64 S-box, indexed by the input nibble.
  localparam nib_t SBOX4 [16] = '{
    4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
    4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF
  };

  // Inverse Skinny-64 S-box, indexed by the substituted nibble.
  localparam nib_t SBOX4_INV [16] = '{
    4'h3, 4'h4, 4'h6, 4'h8, 4'hC, 4'hA, 4'h1, 4'hE,
    4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hB, 4'hD, 4'hF
  };

endpackage

// File: rtl/skinny_sbox4_reg.sv
// Single 4-bit Skinny S-box lookup followed by an output register.
// Latency: 1 cycle from din to dout; registers every cycle, no enable.
// No backpressure; the caller decides when dout is consumed. inv port exists only with SKINNY_SUBCELLS_INV_EN.
module skinny_sbox4_reg
  import skinny_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
`ifdef SKINNY_SUBCELLS_INV_EN
  input  logic inv,
`endif
  input  nib_t din,
  output nib_t dout
);

  nib_t sub;

`ifdef SKINNY_SUBCELLS_INV_EN
  assign sub = inv ? SBOX4_INV[din] : SBOX4[din];
`else
  assign sub = SBOX4[din];
`endif

  // Register the substituted nibble so the lookup is isolated by a flop stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= '0;
    else        dout <= sub;
  end

endmodule

// File: rtl/skinny_subcells_serial.sv
// Nibble-serial Skinny-64 SubCells: one S-box, 16 nibbles streamed LSB nibble first.
// Latency: out_valid is high 18 edges after acceptance, counting the accepting edge.
// Backpressure: one state in flight; in_ready low until DONE handshakes. Optional inverse via SKINNY_SUBCELLS_INV_EN.
module skinny_subcells_serial
  import skinny_pkg::*;
#(
  parameter int NUM_NIB = NUM_NIB_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SKINNY_SUBCELLS_INV_EN
  input  logic        inv,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_state,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_state,
  output logic        busy
);

  if (NUM_NIB != 16) begin : g_bad_num_nib
    $error("skinny_subcells_serial supports NUM_NIB == 16 only");
  end

  fsm_e       st;
  logic [3:0] cnt;
  state_t     in_sr;
  state_t     out_sr;
  nib_t       sbox_q;
  logic       accept;

  assign accept    = (st == IDLE) && in_valid && in_ready;
  assign out_state = out_sr;

`ifdef SKINNY_SUBCELLS_INV_EN
  logic inv_q;

  // Latch the direction at acceptance so a changing inv cannot corrupt a state mid-flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      inv_q <= 1'b0;
    else if (accept) inv_q <= inv;
  end
`endif

  skinny_sbox4_reg u_sbox (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SKINNY_SUBCELLS_INV_EN
    .inv   (inv_q),
`endif
    .din   (in_sr[3:0]),
    .dout  (sbox_q)
  );

  // Control FSM with registered handshake and busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            st       <= RUN;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          // 4-bit counter wraps to 0 on the same edge that leaves RUN.
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) st <= DRAIN;
        end
        DRAIN: begin
          st        <= DONE;
          busy      <= 1'b0;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            st        <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // Input shift register: load on accept, then present one nibble per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           in_sr <= '0;
    else if (accept)      in_sr <= in_state;
    else if (st == RUN)   in_sr <= {4'h0, in_sr[63:4]};
  end

  // Output shift register: S-box results enter at the top, so nibble 0 lands lowest after 16 shifts.
  // RUN cycle 0 is skipped because the S-box register does not yet hold nibble 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_sr <= '0;
    else if ((st == RUN && cnt != 4'd0) || st == DRAIN)
      out_sr <= {sbox_q, out_sr[63:4]};
  end

endmodule

// File: tb/tb_skinny_subcells_serial.sv
// Directed bench for skinny_subcells_serial: hand-computed vectors, immediate-assertion checks.
// Latency is counted in rising edges including the accepting edge.
// Inverse-table step is compiled in only with SKINNY_SUBCELLS_INV_EN.
module tb_skinny_subcells_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_state;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_state;
  logic        busy;
`ifdef SKINNY_SUBCELLS_INV_EN
  logic        inv;
`endif

  int n_cmp = 0;
  int n_err = 0;

  skinny_subcells_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SKINNY_SUBCELLS_INV_EN
    .inv       (inv),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Send one state, wait for the result, optionally stall the consumer, then complete the handshake.
  task automatic xfer(input string tag, input logic [63:0] st, input int hold, input logic [63:0] exp);
    int lat;
    logic [63:0] snap;
    @(negedge clk);
    chk1({tag, "_in_ready_idle"}, in_ready, 1'b1);
    in_valid  = 1'b1;
    in_state  = st;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = '0;
    lat = 1;
    chk1({tag, "_busy_run"}, busy, 1'b1);
    chk1({tag, "_in_ready_run"}, in_ready, 1'b0);
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd18);
    chk({tag, "_result"}, out_state, exp);
    chk1({tag, "_busy_done"}, busy, 1'b0);
    snap = out_state;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk1({tag, "_hold_valid"}, out_valid, 1'b1);
      chk({tag, "_hold_state"}, out_state, snap);
      chk1({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk1({tag, "_valid_drop"}, out_valid, 1'b0);
    chk1({tag, "_in_ready_back"}, in_ready, 1'b1);
    chk({tag, "_state_held"}, out_state, exp);
    out_ready = 1'b0;
  endtask

  initial begin
    int hs;
    logic [63:0] res;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    out_ready = 1'b0;
`ifdef SKINNY_SUBCELLS_INV_EN
    inv       = 1'b0;
`endif
    #1;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_out_state", out_state, 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("post_rst_in_ready", in_ready, 1'b1);

    // All-zero state: every nibble maps 0 -> C.
    xfer("zero", 64'h0, 0, 64'hCCCC_CCCC_CCCC_CCCC);

    // Every nibble value once: checks table and ordering.
    xfer("ramp", 64'h0123_4567_89AB_CDEF, 0, 64'hC690_1A2B_385D_4E7F);

    // F is a fixed point; consumer stalls for 10 cycles.
    xfer("ones_stall", 64'hFFFF_FFFF_FFFF_FFFF, 10, 64'hFFFF_FFFF_FFFF_FFFF);

    // in_valid pulse during RUN must be ignored.
    @(negedge clk);
    in_valid  = 1'b1;
    in_state  = 64'h0123_4567_89AB_CDEF;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_state = 64'hFEDC_BA98_7654_3210;
    @(negedge clk);
    in_valid = 1'b0;
    in_state = '0;
    hs  = 0;
    res = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        hs++;
        res = out_state;
      end
    end
    chk("pulse_handshakes", 64'(hs), 64'd1);
    chk("pulse_result", res, 64'hC690_1A2B_385D_4E7F);
    chk1("pulse_in_ready", in_ready, 1'b1);
    out_ready = 1'b0;

    // Reset in the middle of RUN (counter = 7), then a clean transfer.
    @(negedge clk);
    in_valid = 1'b1;
    in_state = 64'hFEDC_BA98_7654_3210;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = '0;
    repeat (7) @(posedge clk);
    #1;
    chk1("abort_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("abort_in_ready", in_ready, 1'b0);
    chk1("abort_out_valid", out_valid, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk("abort_out_state", out_state, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("abort_ready_after", in_ready, 1'b1);
    xfer("after_abort", 64'h0123_4567_89AB_CDEF, 0, 64'hC690_1A2B_385D_4E7F);

`ifdef SKINNY_SUBCELLS_INV_EN
    inv = 1'b1;
    xfer("inverse", 64'hC690_1A2B_385D_4E7F, 0, 64'h0123_4567_89AB_CDEF);
    inv = 1'b0;
    xfer("forward_again", 64'h0123_4567_89AB_CDEF, 0, 64'hC690_1A2B_385D_4E7F);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
